// File: rtl/alu_scheduler_pkg.sv
// Shared opcode constants, FSM state enum and opcode classification helpers for alu_scheduler.
package alu_scheduler_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_CBNZ = 4'b1111;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic op_is_addsub(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_is_cb(input logic [3:0] op);
    return (op == OP_CBZ) || (op == OP_CBNZ);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_CBZ, OP_CBNZ, OP_AND,
      OP_ORR, OP_EOR, OP_NOR, OP_NAND, OP_MOV: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is accepted.
module alu_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer resets to req1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)       last <= 1'b1;
    else if (accept) last <= grant[1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_SCHED_OPCHK_EN to reject illegal opcodes with rsp_err instead of forwarding them.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_t           state, state_nx;
  logic [1:0]       grant;
  logic             accept;
  logic             op_ok;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;

  alu_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = (state == IDLE) && !reset && grant[0];
  assign req1_ready = (state == IDLE) && !reset && grant[1];
  assign accept     = req0_ready || req1_ready;

`ifdef ALU_SCHED_OPCHK_EN
  assign op_ok = op_legal(op_q);
`else
  assign op_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rsp_valid   = 1'b0;
    alu_control = OP_MOV;
    alu_data1   = '0;
    alu_data2   = '0;
    case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: begin
        state_nx = RESP;
        if (op_ok) begin
          alu_control = op_q;
          alu_data1   = a_q;
          alu_data2   = b_q;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_MOV;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= grant[1] ? req1_op : req0_op;
      a_q  <= grant[1] ? req1_a  : req0_a;
      b_q  <= grant[1] ? req1_b  : req0_b;
      id_q <= grant[1];
    end
  end

  // Flags are masked to the op classes that define them; compare ops return a zero result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id       <= id_q;
      rsp_result   <= (op_ok && !op_is_cb(op_q)) ? alu_result : '0;
      rsp_overflow <= op_ok && op_is_addsub(op_q) && alu_overflow;
      rsp_zero     <= op_ok && op_is_cb(op_q) && alu_zero;
      rsp_err      <= !op_ok;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized scoreboard bench for alu_scheduler with a behavioural ALU and request-level reference model.
module tb_alu_scheduler;

  localparam int W = 32;
`ifdef ALU_SCHED_OPCHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_data1, alu_data2, alu_result;
  logic         alu_overflow, alu_zero;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_err;

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  typedef struct packed { logic ovf; logic zero; logic [W-1:0] res; } alu_out_t;
  typedef struct packed { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
  typedef struct {
    logic id; logic [W-1:0] res; logic ovf; logic zero; logic err;
    logic [3:0] ctl; logic [W-1:0] d1; logic [W-1:0] d2;
    int exec_cyc; int due; bit seen;
  } ent_t;

  // Flags are noisy on ops that do not define them, so any leak shows up in rsp_*.
  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_out_t o;
    case (op)
      4'b0010: o.res = a + b;
      4'b1010: o.res = a - b;
      4'b0110: o.res = a & b;
      4'b0100: o.res = a | b;
      4'b1001: o.res = a ^ b;
      4'b0101: o.res = ~(a | b);
      4'b1100: o.res = ~(a & b);
      4'b1101, 4'b0111, 4'b1111: o.res = b;
      default: o.res = ~a ^ b;
    endcase
    o.ovf  = o.res[1];
    o.zero = ~o.res[0];
    if (op == 4'b0010) o.ovf = (a[W-1] == b[W-1]) && (o.res[W-1] != a[W-1]);
    if (op == 4'b1010) o.ovf = (a[W-1] != b[W-1]) && (o.res[W-1] != a[W-1]);
    if (op == 4'b0111) o.zero = (b == '0);
    if (op == 4'b1111) o.zero = (b != '0);
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_fn(alu_control, alu_data1, alu_data2);
  assign alu_result   = alu_o.res;
  assign alu_overflow = alu_o.ovf;
  assign alu_zero     = alu_o.zero;

  logic [3:0] legal_ops [10] = '{4'b0010, 4'b1010, 4'b0111, 4'b1111, 4'b0110,
                                 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b1101};

  function automatic ent_t ref_rsp(input req_t r, input logic id);
    ent_t e;
    alu_out_t o;
    bit legal, cb, addsub;
    legal = !CHK_EN;
    foreach (legal_ops[i]) if (legal_ops[i] == r.op) legal = 1'b1;
    cb     = (r.op == 4'b0111) || (r.op == 4'b1111);
    addsub = (r.op == 4'b0010) || (r.op == 4'b1010);
    o = alu_fn(r.op, r.a, r.b);
    e.id   = id;
    e.err  = !legal;
    e.res  = (legal && !cb) ? o.res : '0;
    e.ovf  = legal && addsub && o.ovf;
    e.zero = legal && cb && o.zero;
    e.ctl  = legal ? r.op : 4'b1101;
    e.d1   = legal ? r.a : '0;
    e.d2   = legal ? r.b : '0;
    e.exec_cyc = 0; e.due = 0; e.seen = 1'b0;
    return e;
  endfunction

  int   total = 0, bad = 0, cyc = 0;
  req_t q0[$], q1[$];
  ent_t sb[$];
  bit   busy = 1'b0, last_g = 1'b1, rand_rr = 1'b0, rst_exec = 1'b0;
  int   due = 0, stall = 0, rst_cycles = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 9)];
    r.a  = $urandom();
    r.b  = ($urandom_range(0, 3) == 0) ? '0 : $urandom();
    return r;
  endfunction

  // One clock: drive at the falling edge, check readies and advance the model before the rising edge.
  task automatic cycle();
    logic [1:0] exp_rdy;
    int win;
    req_t r;
    ent_t e;
    @(negedge clk);
    reset = 1'b0;
    if (rst_cycles > 0) begin reset = 1'b1; rst_cycles--; end
    if (rst_exec && busy && cyc == due - 1) begin reset = 1'b1; rst_exec = 1'b0; end
    rsp_ready = (stall > 0) ? 1'b0 : (rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall > 0) stall--;
    r = (q0.size() > 0) ? q0[0] : rnd_req();
    req0_valid = q0.size() > 0; req0_op = r.op; req0_a = r.a; req0_b = r.b;
    r = (q1.size() > 0) ? q1[0] : rnd_req();
    req1_valid = q1.size() > 0; req1_op = r.op; req1_a = r.a; req1_b = r.b;
    #2;
    win = -1;
    if (!reset && !busy) begin
      if (q0.size() > 0 && q1.size() > 0) win = last_g ? 0 : 1;
      else if (q0.size() > 0)             win = 0;
      else if (q1.size() > 0)             win = 1;
    end
    exp_rdy = 2'b00;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("ready", {req1_ready, req0_ready}, exp_rdy);
    if (reset) begin
      busy = 1'b0; last_g = 1'b1; sb.delete();
    end else if (win >= 0) begin
      r = (win == 1) ? q1.pop_front() : q0.pop_front();
      e = ref_rsp(r, win[0]);
      e.exec_cyc = cyc + 1; e.due = cyc + 2;
      sb.push_back(e);
      busy = 1'b1; due = cyc + 2; last_g = win[0];
    end else if (busy && cyc >= due && rsp_ready) begin
      busy = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 400) begin cycle(); n++; end
    chk("drain_in_time", n < 400, 1);
    cycle(); cycle();
  endtask

  always @(negedge clk) begin
    #3;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].exec_cyc == cyc) begin
        chk("exec_ctl", alu_control, sb[0].ctl);
        chk("exec_d1", alu_data1, sb[0].d1);
        chk("exec_d2", alu_data2, sb[0].d2);
      end else begin
        chk("idle_ctl", alu_control, 4'b1101);
        chk("idle_d1", alu_data1, 0);
        chk("idle_d2", alu_data2, 0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          if (!sb[0].seen) begin chk("latency", cyc, sb[0].due); sb[0].seen = 1'b1; end
          chk("rsp_id", rsp_id, sb[0].id);
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_overflow", rsp_overflow, sb[0].ovf);
          chk("rsp_zero", rsp_zero, sb[0].zero);
          chk("rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        chk("rsp_missing", 0, 1);
      end
    end
  end

  initial begin
    cycle();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_readies", {req1_ready, req0_ready}, 0);
    while (rst_cycles > 0) cycle();
    cycle();
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_result", rsp_result, 0);
    chk("post_rst_ovf", rsp_overflow, 0);
    chk("post_rst_zero", rsp_zero, 0);
    chk("post_rst_err", rsp_err, 0);
    chk("post_rst_ctl", alu_control, 4'b1101);

    q0.push_back('{4'b0010, 32'd5, 32'd7});
    drain();
    chk("add_5_7_result", alu_fn(4'b0010, 32'd5, 32'd7).res, 32'd12);

    rst_cycles = 1;
    repeat (2) begin
      q0.push_back('{4'b1010, 32'd3, 32'd5});
      q1.push_back('{4'b0110, 32'hF0, 32'h3C});
    end
    drain();

    q1.push_back('{4'b0111, 32'h1234, 32'd0});
    q1.push_back('{4'b1111, 32'h1234, 32'd0});
    drain();

    q0.push_back('{4'b0100, 32'hA0, 32'h0B});
    q0.push_back('{4'b0100, 32'h11, 32'h22});
    for (int i = 0; i < 20 && !busy; i++) cycle();
    stall = 6;
    drain();

    repeat (2) begin
      q0.push_back('{4'b1001, $urandom(), $urandom()});
      q1.push_back('{4'b0101, $urandom(), $urandom()});
    end
    rst_exec = 1'b1;
    drain();
    chk("rst_in_exec_hit", rst_exec, 0);

    q0.push_back('{4'b0000, 32'h55, 32'h0F});
    drain();

    rand_rr = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rnd_req());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rnd_req());
      if ($urandom_range(0, 149) == 0) rst_cycles = 1;
      cycle();
    end
    rand_rr = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1  requester N holds an operation.
REQ-005 The block SHALL have ports req0_ready/req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 The block SHALL have ports req0_op/req1_op  input  4  aluControl code; req0_a/req1_a, req0_b/req1_b  input  WIDTH  data1/data2 operands.
REQ-007 The block SHALL have ports alu_control  output  4, alu_data1/alu_data2  output  WIDTH  drive to the shared combinational ALU.
REQ-008 The block SHALL have ports alu_result  input  WIDTH, alu_overflow  input  1, alu_zero  input  1  ALU outputs.
REQ-009 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_result  output  WIDTH, rsp_overflow  output  1, rsp_zero  output  1, rsp_err  output  1.

Function
REQ-010 The FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1, else hold RESP.
REQ-011 In IDLE, reqN_ready SHALL be 1 only for the arbitration winner with reqN_valid=1; both readies 0 in EXEC and RESP.
REQ-012 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last; last-grant pointer updates only on accept.
REQ-013 On accept, op, a, b and id SHALL be registered; in EXEC, alu_control/alu_data1/alu_data2 SHALL drive the registered values and ALU outputs SHALL be captured at the end of EXEC.
REQ-014 Latency: accept at edge N, rsp_valid=1 from cycle N+2; rsp fields SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-015 rsp_overflow SHALL equal captured alu_overflow for ops 0010/1010, else 0.
REQ-016 rsp_zero SHALL equal captured alu_zero for ops 0111/1111, else 0.
REQ-017 rsp_result SHALL equal captured alu_result for all other accepted ops; for 0111/1111 rsp_result SHALL be 0.
REQ-018 Outside EXEC, alu_control SHALL be 1101 (MOV) and alu_data1/alu_data2 SHALL be 0.
REQ-019 Maximum throughput SHALL be one operation per 3 cycles with rsp_ready held 1.

Reset
REQ-020 Reset SHALL force IDLE, last-grant pointer = req1 (req0 wins first tie), discard any pending operation without response.
REQ-021 During/after reset: reqN_ready=0 (until IDLE evaluation), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_zero=0, rsp_err=0, alu outputs per REQ-018.

Configuration
REQ-022 Macro ALU_SCHED_OPCHK_EN SHALL enable opcode checking: legal set {0010,1010,0111,1111,0110,0100,1001,0101,1100,1101}.
REQ-023 With ALU_SCHED_OPCHK_EN defined, an illegal op SHALL be accepted, skip ALU drive in EXEC (REQ-018 values), and respond with rsp_err=1, rsp_result=0, flags 0, same latency.
REQ-024 Without ALU_SCHED_OPCHK_EN, every op SHALL be forwarded to the ALU and rsp_err SHALL be constant 0.

Structure
REQ-025 A shared package SHALL hold the 4-bit ALU opcode constants (ADD, SUB, CBZ, CBNZ, AND, ORR, EOR, NOR, NAND, MOV) and the FSM state enum.
REQ-026 The round-robin arbiter SHALL be one sub-module, alu_rr_arb (2 requests, pointer, grant, accept-update).

Verification
REQ-027 req0 ADD a=5 b=7 alone -> req0_ready at N, alu_control=0010 in EXEC, rsp_valid at N+2, rsp_id=0, rsp_result=12, rsp_overflow=0.
REQ-028 Both valid continuously after reset (req0 SUB 3-5, req1 AND F0&3C) -> grants alternate req0, req1, req0; results -2 then 0x30.
REQ-029 req1 CBZ b=0 then CBNZ b=0 -> rsp_zero=1 then 0, rsp_result=0 both.
REQ-030 rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, readies 0, no new accept; rsp_ready=1 -> IDLE next cycle.
REQ-031 reset asserted during EXEC -> next cycle IDLE, rsp_valid never asserted for that op, next tie granted to req0.
REQ-032 With ALU_SCHED_OPCHK_EN, op 0000 -> rsp_err=1, rsp_result=0, alu_control=1101 in EXEC; without macro -> rsp_err=0, ALU sees 0000.
